// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter_if
// Description : Bundle of the two requester ports and the single-port data
//               memory bus handled by data_mem_arbiter.
//               Requester side : req/we/addr/wdata/lock in, gnt/rvalid/rdata out
//               Memory side    : mem_read_en/mem_write_en/mem_address/
//                                mem_write_data out, mem_read_data in
//               modport slave  : the arbiter
//               modport master : the requesters plus the memory
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_arbiter_if #(
    parameter int N = 8
);
    // Port 0: processor load/store path
    logic         req0;
    logic         we0;
    logic [N-1:0] addr0;
    logic [N-1:0] wdata0;
    logic         lock0;
    logic         gnt0;
    logic         rvalid0;
    logic [N-1:0] rdata0;

    // Port 1: loader / debug DMA
    logic         req1;
    logic         we1;
    logic [N-1:0] addr1;
    logic [N-1:0] wdata1;
    logic         lock1;
    logic         gnt1;
    logic         rvalid1;
    logic [N-1:0] rdata1;

    // Single-port synchronous memory
    logic         mem_read_en;
    logic         mem_write_en;
    logic [N-1:0] mem_address;
    logic [N-1:0] mem_write_data;
    logic [N-1:0] mem_read_data;

    modport slave (
        input  req0, we0, addr0, wdata0, lock0,
        input  req1, we1, addr1, wdata1, lock1,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_read_en, mem_write_en, mem_address, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output req0, we0, addr0, wdata0, lock0,
        output req1, we1, addr1, wdata1, lock1,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_read_en, mem_write_en, mem_address, mem_write_data,
        output mem_read_data
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Shares one single-port synchronous data memory between the
//               processor (port 0) and the loader/debug DMA (port 1). One
//               access per cycle, round-robin on contention, optional bounded
//               lock so a port can finish a burst. Read data is steered back
//               to the port that issued the read, one cycle after the grant.
// Ports       : clk  - single clock, rising edge
//               rst  - synchronous reset, active-high
//               bus  - data_mem_arbiter_if.slave (requesters + memory bus)
// Parameters  : N         - data and address width
//               MAX_BURST - max consecutive locked grants while the other
//                           port is waiting (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int N         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_arbiter_if.slave     bus
);

    localparam int                 c_CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_BURST);
    localparam logic [c_CNT_W-1:0] c_ONE_CNT = c_CNT_W'(1);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               r_state;
    logic                 r_owner;      // port holding the lock
    logic                 r_last;       // port granted most recently
    logic [c_CNT_W-1:0]   r_burst_cnt;  // locked grants in the current burst
    logic                 r_rd_pend;    // read issued last cycle
    logic                 r_rd_tag;     // issuer of that read

    state_t               w_state_nxt;
    logic                 w_owner_nxt;
    logic                 w_last_nxt;
    logic [c_CNT_W-1:0]   w_burst_nxt;

    // ------------------------------------------------------------------
    // Request vectors indexed by port number
    // ------------------------------------------------------------------
    logic [1:0]           w_req;
    logic [1:0]           w_lock;
    logic [1:0]           w_we;

    assign w_req  = {bus.req1,  bus.req0};
    assign w_lock = {bus.lock1, bus.lock0};
    assign w_we   = {bus.we1,   bus.we0};

    // Plain round-robin choice: on a tie the port that did not win last.
    logic                 w_arb_valid;
    logic                 w_arb_port;

    assign w_arb_valid = bus.req0 | bus.req1;
    assign w_arb_port  = (bus.req0 & bus.req1) ? ~r_last : bus.req1;

    // The owner keeps the memory while it still asks for the lock, unless
    // the other port is waiting and the burst has reached its bound.
    logic                 w_hold;

    assign w_hold = (r_state == ST_LOCK)
                  & w_req[r_owner]
                  & w_lock[r_owner]
                  & (~w_req[~r_owner] | (r_burst_cnt < c_MAX_CNT));

    // ------------------------------------------------------------------
    // Next-state / grant selection
    // ------------------------------------------------------------------
    logic                 w_gnt_valid;
    logic                 w_gnt_port;

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_port  = 1'b0;
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_burst_nxt = r_burst_cnt;

        if (w_hold) begin
            w_gnt_valid = 1'b1;
            w_gnt_port  = r_owner;
            w_state_nxt = ST_LOCK;
            w_last_nxt  = r_owner;
            if (r_burst_cnt < c_MAX_CNT) begin
                w_burst_nxt = r_burst_cnt + c_ONE_CNT;
            end
        end else begin
            // Lock not held (or released/expired): arbitrate in this very
            // cycle so a released lock costs no idle cycle.
            w_state_nxt = ST_ARB;
            w_burst_nxt = '0;
            if (w_arb_valid) begin
                w_gnt_valid = 1'b1;
                w_gnt_port  = w_arb_port;
                w_last_nxt  = w_arb_port;
                if (w_lock[w_arb_port]) begin
                    w_state_nxt = ST_LOCK;
                    w_owner_nxt = w_arb_port;
                    w_burst_nxt = c_ONE_CNT;
                end
            end
        end
    end

    // Nothing is issued while reset is held, even though requests may be up.
    logic                 w_issue;
    logic                 w_issue_read;

    assign w_issue      = w_gnt_valid & ~rst;
    assign w_issue_read = w_issue & ~w_we[w_gnt_port];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ARB;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_burst_cnt <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_tag    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_rd_pend   <= w_issue_read;
            if (w_issue_read) begin
                r_rd_tag <= w_gnt_port;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.gnt0 = w_issue & ~w_gnt_port;
    assign bus.gnt1 = w_issue &  w_gnt_port;

    assign bus.mem_read_en    = w_issue_read;
    assign bus.mem_write_en   = w_issue & w_we[w_gnt_port];
    assign bus.mem_address    = ~w_issue ? '0 :
                                (w_gnt_port ? bus.addr1 : bus.addr0);
    assign bus.mem_write_data = ~w_issue ? '0 :
                                (w_gnt_port ? bus.wdata1 : bus.wdata0);

    // A read in flight when reset arrives is dropped, never delivered.
    assign bus.rvalid0 = r_rd_pend & ~rst & ~r_rd_tag;
    assign bus.rvalid1 = r_rd_pend & ~rst &  r_rd_tag;
    assign bus.rdata0  = bus.mem_read_data;
    assign bus.rdata1  = bus.mem_read_data;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Self-checking bench for data_mem_arbiter. A behavioural
//               memory sits on the memory bus; a reference model predicts
//               every grant and memory strobe, and queues expected read
//               responses which a monitor matches against rvalid/rdata.
//               Directed scenarios are followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    localparam int N         = 8;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    data_mem_arbiter_if #(.N(N)) bus ();

    data_mem_arbiter #(.N(N), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ------------------------------------------------------------------
    // Behavioural single-port synchronous memory
    // ------------------------------------------------------------------
    logic [N-1:0] mem     [256];
    logic [N-1:0] ref_mem [256];

    always @(posedge clk) begin
        if (bus.mem_write_en) mem[bus.mem_address] <= bus.mem_write_data;
        if (bus.mem_read_en)  bus.mem_read_data    <= mem[bus.mem_address];
    end

    // ------------------------------------------------------------------
    // Scoreboard and counters
    // ------------------------------------------------------------------
    typedef struct {
        int           port;
        logic [N-1:0] data;
        int           due;
    } rd_exp_t;

    rd_exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model state: who won last, who holds a lock and how many
    // consecutive locked grants it has had.
    // ------------------------------------------------------------------
    int m_last  = 1;
    int m_owner = -1;
    int m_run   = 0;

    always @(negedge clk) begin : monitor
        logic [1:0]   req, lk, we;
        logic [N-1:0] ad [2];
        logic [N-1:0] wd [2];
        int           g;
        bit           cont;
        bit           ev0, ev1;
        logic [N-1:0] ed;
        rd_exp_t      e;

        cyc++;
        req = {bus.req1, bus.req0};
        lk  = {bus.lock1, bus.lock0};
        we  = {bus.we1, bus.we0};
        ad[0] = bus.addr0;  ad[1] = bus.addr1;
        wd[0] = bus.wdata0; wd[1] = bus.wdata1;

        if (rst) begin
            check("rst_gnt0",    bus.gnt0, 0);
            check("rst_gnt1",    bus.gnt1, 0);
            check("rst_rd_en",   bus.mem_read_en, 0);
            check("rst_wr_en",   bus.mem_write_en, 0);
            check("rst_addr",    bus.mem_address, 0);
            check("rst_rvalid0", bus.rvalid0, 0);
            check("rst_rvalid1", bus.rvalid1, 0);
            m_last  = 1;
            m_owner = -1;
            m_run   = 0;
            sb_q.delete();
        end else begin
            // Read returns due this cycle
            ev0 = 0; ev1 = 0; ed = '0;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e  = sb_q.pop_front();
                ed = e.data;
                if (e.port == 0) ev0 = 1; else ev1 = 1;
            end
            check("rvalid0", bus.rvalid0, ev0);
            check("rvalid1", bus.rvalid1, ev1);
            if (ev0) check("rdata0", bus.rdata0, ed);
            if (ev1) check("rdata1", bus.rdata1, ed);

            // Expected grant this cycle
            g = -1; cont = 0;
            if (m_owner >= 0 && req[m_owner] && lk[m_owner] &&
                (!req[1-m_owner] || m_run < MAX_BURST)) begin
                g = m_owner; cont = 1;
            end else if (req[0] && req[1]) begin
                g = 1 - m_last;
            end else if (req[0]) begin
                g = 0;
            end else if (req[1]) begin
                g = 1;
            end

            check("gnt0", bus.gnt0, g == 0);
            check("gnt1", bus.gnt1, g == 1);
            if (g >= 0) begin
                check("mem_read_en",  bus.mem_read_en,  !we[g]);
                check("mem_write_en", bus.mem_write_en, we[g]);
                check("mem_address",  bus.mem_address,  ad[g]);
                if (we[g]) check("mem_write_data", bus.mem_write_data, wd[g]);
                if (!we[g]) begin
                    e.port = g; e.data = ref_mem[ad[g]]; e.due = cyc + 1;
                    sb_q.push_back(e);
                end else begin
                    ref_mem[ad[g]] = wd[g];
                end
                if (cont) begin
                    if (m_run < MAX_BURST) m_run++;
                end else if (lk[g]) begin
                    m_owner = g; m_run = 1;
                end else begin
                    m_owner = -1; m_run = 0;
                end
                m_last = g;
            end else begin
                check("idle_rd_en", bus.mem_read_en, 0);
                check("idle_wr_en", bus.mem_write_en, 0);
                check("idle_addr",  bus.mem_address, 0);
                check("idle_wdata", bus.mem_write_data, 0);
                m_owner = -1; m_run = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int  exp_lock [6] = '{1, 1, 1, 1, 0, 1};
    int  gseq;
    bit  g0, g1;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = N'(i * 7 + 3);
            ref_mem[i] = N'(i * 7 + 3);
        end
        bus.mem_read_data = '0;

        // Reset with both ports requesting, then round-robin reads
        rst = 1'b1;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h20; bus.wdata0 = 0; bus.lock0 = 0;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h30; bus.wdata1 = 0; bus.lock1 = 0;
        @(posedge clk);
        @(negedge clk);
        check("reset_gnt0", bus.gnt0, 0);
        check("reset_gnt1", bus.gnt1, 0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_gnt0", bus.gnt0, (i % 2) == 0);
            check("rr_gnt1", bus.gnt1, (i % 2) == 1);
            next_cycle();
        end
        bus.req0 = 0; bus.req1 = 0;
        next_cycle();

        // Bounded lock by port 1 while port 0 waits
        bus.req1 = 1; bus.we1 = 1; bus.lock1 = 1; bus.addr1 = 8'h40; bus.wdata1 = 8'h11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            gseq = bus.gnt1 ? 1 : (bus.gnt0 ? 0 : -1);
            check("lock_seq", gseq, exp_lock[i]);
            check("lock_wr_en", bus.mem_write_en, 1);
            g0 = bus.gnt0; g1 = bus.gnt1;
            next_cycle();
            if (g1) begin bus.addr1 += 1; bus.wdata1 += 1; end
            if (g0) begin bus.addr0 += 1; bus.wdata0 += 1; end
            if (i == 0) begin
                bus.req0 = 1; bus.we0 = 1; bus.lock0 = 0;
                bus.addr0 = 8'h50; bus.wdata0 = 8'h22;
            end
        end
        bus.req0 = 0; bus.req1 = 0; bus.lock1 = 0; bus.we0 = 0; bus.we1 = 0;
        next_cycle();

        // Write then read back from both ports
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h12; bus.wdata0 = 8'hA5;
        @(negedge clk);
        check("wr_gnt0", bus.gnt0, 1);
        check("wr_addr", bus.mem_address, 8'h12);
        check("wr_data", bus.mem_write_data, 8'hA5);
        next_cycle();
        bus.we0 = 0;
        @(negedge clk);
        check("rd_gnt0", bus.gnt0, 1);
        next_cycle();
        bus.req0 = 0;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h12;
        @(negedge clk);
        check("rb_rvalid0", bus.rvalid0, 1);
        check("rb_rdata0",  bus.rdata0, 8'hA5);
        check("rd_gnt1",    bus.gnt1, 1);
        next_cycle();
        bus.req1 = 0;
        @(negedge clk);
        check("rb_rvalid1", bus.rvalid1, 1);
        check("rb_rdata1",  bus.rdata1, 8'hA5);
        next_cycle();

        // Reset with a read in flight
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h12;
        @(negedge clk);
        check("mid_gnt0", bus.gnt0, 1);
        next_cycle();
        rst = 1'b1; bus.req0 = 0;
        @(negedge clk);
        check("mid_rvalid0_rst", bus.rvalid0, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rvalid0_after", bus.rvalid0, 0);
        next_cycle();

        // Lock owner drops its request mid-burst
        bus.req0 = 1; bus.we0 = 0; bus.lock0 = 1; bus.addr0 = 8'h03;
        bus.req1 = 1; bus.we1 = 0; bus.lock1 = 0; bus.addr1 = 8'h04;
        @(negedge clk);
        check("rel_gnt0_a", bus.gnt0, 1);
        next_cycle();
        bus.addr0 = 8'h05;
        @(negedge clk);
        check("rel_gnt0_b", bus.gnt0, 1);
        next_cycle();
        bus.req0 = 0; bus.lock0 = 0;
        @(negedge clk);
        check("rel_gnt1", bus.gnt1, 1);
        next_cycle();
        bus.req1 = 0;

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g0 = bus.gnt0; g1 = bus.gnt1;
            next_cycle();
            rst = ($urandom_range(0, 299) == 0);
            if (!bus.req0 || g0) begin
                bus.req0   = ($urandom_range(0, 2) != 0);
                bus.we0    = 1'($urandom_range(0, 1));
                bus.addr0  = N'($urandom_range(0, 15));
                bus.wdata0 = N'($urandom);
                bus.lock0  = 1'($urandom_range(0, 1));
            end
            if (!bus.req1 || g1) begin
                bus.req1   = ($urandom_range(0, 2) != 0);
                bus.we1    = 1'($urandom_range(0, 1));
                bus.addr1  = N'($urandom_range(0, 15));
                bus.wdata1 = N'($urandom);
                bus.lock1  = 1'($urandom_range(0, 1));
            end
        end
        rst = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.lock0 = 0; bus.lock1 = 0;
        repeat (4) next_cycle();
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
